// File: rtl/rf_pkg.sv
// Shared widths, source indices and the writeback request record used by the
// register-file write-port arbiter.
package rf_pkg;

   localparam int XLEN = 32;
   localparam int RAW  = 5;

   localparam int SRC_MULDIV = 0;
   localparam int SRC_LOAD   = 1;

   typedef struct packed {
      logic            valid;
      logic [RAW-1:0]  rd;
      logic [XLEN-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant among req when enabled, with the
// pointer flipped after any grant.
module rr_arb2 (
   input  logic       en,
   input  logic [1:0] req,
   input  logic       ptr,
   output logic [1:0] gnt,
   output logic       ptr_nxt
);

   always_comb begin
      gnt = 2'b00;
      if (en) begin
         unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
         endcase
      end
      ptr_nxt = (|gnt) ? ~ptr : ptr;
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register file's single write port between the pipeline WB stage
// (absolute priority) and two secondary sources served round-robin.
module rf_wb_arbiter #(
   parameter int XLEN         = rf_pkg::XLEN,
   parameter int RAW          = rf_pkg::RAW,
   parameter int STARVE_LIMIT = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            p_valid,
   input  logic [RAW-1:0]  p_rd,
   input  logic [XLEN-1:0] p_data,
   input  logic [1:0]      s_valid,
   input  logic [RAW-1:0]  s_rd0,
   input  logic [RAW-1:0]  s_rd1,
   input  logic [XLEN-1:0] s_data0,
   input  logic [XLEN-1:0] s_data1,
   output logic [1:0]      s_ready,
   output logic            stall_req,
   output logic            rf_wr,
   output logic [RAW-1:0]  rf_wregnum,
   output logic [XLEN-1:0] rf_wd
);
   import rf_pkg::*;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   // Handshake: secondary i transfers in any cycle where s_valid[i] && s_ready[i];
   // the requester keeps s_valid/s_rd/s_data stable until then, and s_ready never
   // depends on anything but current inputs and registered state.
   wb_req_t    sec [2];
   logic       pipe_hit;
   logic       rr_ptr, rr_ptr_nxt;
   logic [1:0] gnt;
   logic [3:0] wait_cnt [2];
   logic [3:0] wait_nxt [2];
   logic       stall_nxt;
   wb_req_t    sel;

   assign sec[SRC_MULDIV] = '{valid: s_valid[SRC_MULDIV], rd: s_rd0, data: s_data0};
   assign sec[SRC_LOAD]   = '{valid: s_valid[SRC_LOAD],   rd: s_rd1, data: s_data1};

   // A pipeline write to x0 is dropped and leaves the slot free for a secondary.
   assign pipe_hit = p_valid && (p_rd != '0);

   rr_arb2 u_rr (
      .en      (!pipe_hit),
      .req     (s_valid),
      .ptr     (rr_ptr),
      .gnt     (gnt),
      .ptr_nxt (rr_ptr_nxt)
   );

   assign s_ready = gnt;
   assign sel     = gnt[SRC_LOAD] ? sec[SRC_LOAD] : sec[SRC_MULDIV];

   always_comb begin
      stall_nxt = 1'b0;
      for (int i = 0; i < 2; i++) begin
         wait_nxt[i] = '0;
         if (s_valid[i] && !s_ready[i])
            wait_nxt[i] = (wait_cnt[i] == LIMIT) ? LIMIT : wait_cnt[i] + 4'd1;
         if (wait_nxt[i] == LIMIT)
            stall_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_wr       <= 1'b0;
         rf_wregnum  <= '0;
         rf_wd       <= '0;
         stall_req   <= 1'b0;
         rr_ptr      <= 1'b0;
         wait_cnt[0] <= '0;
         wait_cnt[1] <= '0;
      end else begin
         rr_ptr      <= rr_ptr_nxt;
         wait_cnt[0] <= wait_nxt[0];
         wait_cnt[1] <= wait_nxt[1];
         stall_req   <= stall_nxt;
         if (pipe_hit) begin
            rf_wr      <= 1'b1;
            rf_wregnum <= p_rd;
            rf_wd      <= p_data;
         end else if ((|gnt) && (sel.rd != '0)) begin
            rf_wr      <= 1'b1;
            rf_wregnum <= sel.rd;
            rf_wd      <= sel.data;
         end else begin
            rf_wr <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: reset, pipeline priority, round-robin,
// starvation stall, x0 discard and pipeline/secondary back-to-back writes.
module tb_rf_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        p_valid;
   logic [4:0]  p_rd;
   logic [31:0] p_data;
   logic [1:0]  s_valid;
   logic [4:0]  s_rd0, s_rd1;
   logic [31:0] s_data0, s_data1;
   logic [1:0]  s_ready;
   logic        stall_req;
   logic        rf_wr;
   logic [4:0]  rf_wregnum;
   logic [31:0] rf_wd;

   int checks = 0;
   int errors = 0;

   rf_wb_arbiter #(.XLEN(32), .RAW(5), .STARVE_LIMIT(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .p_valid    (p_valid),
      .p_rd       (p_rd),
      .p_data     (p_data),
      .s_valid    (s_valid),
      .s_rd0      (s_rd0),
      .s_rd1      (s_rd1),
      .s_data0    (s_data0),
      .s_data1    (s_data1),
      .s_ready    (s_ready),
      .stall_req  (stall_req),
      .rf_wr      (rf_wr),
      .rf_wregnum (rf_wregnum),
      .rf_wd      (rf_wd)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      p_valid = 1'b0; p_rd = '0; p_data = '0;
      s_valid = 2'b00; s_rd0 = '0; s_rd1 = '0; s_data0 = '0; s_data1 = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      #1;
      checks++; if (rf_wr !== 1'b0)      begin errors++; $display("FAIL reset_rf_wr got %b exp 0", rf_wr); end
      checks++; if (stall_req !== 1'b0)  begin errors++; $display("FAIL reset_stall got %b exp 0", stall_req); end
      checks++; if (rf_wregnum !== 5'd0) begin errors++; $display("FAIL reset_wregnum got %0d exp 0", rf_wregnum); end
      checks++; if (rf_wd !== 32'd0)     begin errors++; $display("FAIL reset_wd got %h exp 0", rf_wd); end
      cyc(); cyc();
      rst = 1'b0;
   endtask

   task automatic test_reset_mid_write();
      p_valid = 1'b1; p_rd = 5'd17; p_data = 32'h1111_2222;
      cyc();
      idle_inputs();
      checks++; if (rf_wr !== 1'b1) begin errors++; $display("FAIL midrst_pending got %b exp 1", rf_wr); end
      #2 rst = 1'b1;
      #1;
      checks++; if (rf_wr !== 1'b0)      begin errors++; $display("FAIL midrst_rf_wr got %b exp 0", rf_wr); end
      checks++; if (rf_wregnum !== 5'd0) begin errors++; $display("FAIL midrst_wregnum got %0d exp 0", rf_wregnum); end
      checks++; if (rf_wd !== 32'd0)     begin errors++; $display("FAIL midrst_wd got %h exp 0", rf_wd); end
      checks++; if (stall_req !== 1'b0)  begin errors++; $display("FAIL midrst_stall got %b exp 0", stall_req); end
      cyc();
      #2 rst = 1'b0;
      cyc();
   endtask

   task automatic test_pipeline();
      p_valid = 1'b1; p_rd = 5'd5; p_data = 32'hDEAD_BEEF; s_valid = 2'b01; s_rd0 = 5'd8;
      #1;
      checks++; if (s_ready !== 2'b00) begin errors++; $display("FAIL pipe_blocks_sec got %b exp 00", s_ready); end
      s_valid = 2'b00;
      cyc();
      checks++; if (rf_wr !== 1'b1)          begin errors++; $display("FAIL pipe_wr got %b exp 1", rf_wr); end
      checks++; if (rf_wregnum !== 5'd5)     begin errors++; $display("FAIL pipe_rd got %0d exp 5", rf_wregnum); end
      checks++; if (rf_wd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL pipe_wd got %h exp deadbeef", rf_wd); end
      p_rd = 5'd0; p_data = 32'h0000_1234;
      cyc();
      checks++; if (rf_wr !== 1'b0)          begin errors++; $display("FAIL pipe_x0_wr got %b exp 0", rf_wr); end
      checks++; if (rf_wregnum !== 5'd5)     begin errors++; $display("FAIL pipe_x0_hold_rd got %0d exp 5", rf_wregnum); end
      checks++; if (rf_wd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL pipe_x0_hold_wd got %h exp deadbeef", rf_wd); end
      idle_inputs();
      cyc();
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_gnt [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
      logic [4:0]  exp_rd;
      logic [31:0] exp_wd;
      s_valid = 2'b11; s_rd0 = 5'd7; s_rd1 = 5'd9;
      for (int k = 0; k < 4; k++) begin
         s_data0 = 32'hA000_0000 + k;
         s_data1 = 32'hB000_0000 + k;
         exp_rd = exp_gnt[k][0] ? 5'd7 : 5'd9;
         exp_wd = exp_gnt[k][0] ? 32'hA000_0000 + k : 32'hB000_0000 + k;
         #1;
         checks++; if (s_ready !== exp_gnt[k]) begin errors++; $display("FAIL rr_grant[%0d] got %b exp %b", k, s_ready, exp_gnt[k]); end
         cyc();
         checks++; if (rf_wr !== 1'b1)        begin errors++; $display("FAIL rr_wr[%0d] got %b exp 1", k, rf_wr); end
         checks++; if (rf_wregnum !== exp_rd) begin errors++; $display("FAIL rr_rd[%0d] got %0d exp %0d", k, rf_wregnum, exp_rd); end
         checks++; if (rf_wd !== exp_wd)      begin errors++; $display("FAIL rr_wd[%0d] got %h exp %h", k, rf_wd, exp_wd); end
         checks++; if (stall_req !== 1'b0)    begin errors++; $display("FAIL rr_stall[%0d] got %b exp 0", k, stall_req); end
      end
      idle_inputs();
      cyc();
   endtask

   // rr_ptr is back at 0 here; a lone muldiv grant flips it to 1.
   task automatic test_starvation();
      s_valid = 2'b01; s_rd0 = 5'd12; s_data0 = 32'h5555_AAAA;
      p_valid = 1'b1; p_rd = 5'd3;
      for (int k = 1; k <= 5; k++) begin
         p_data = 32'h3000_0000 + k;
         #1;
         checks++; if (s_ready !== 2'b00) begin errors++; $display("FAIL starve_ready[%0d] got %b exp 00", k, s_ready); end
         cyc();
         checks++; if (rf_wregnum !== 5'd3) begin errors++; $display("FAIL starve_pipe_rd[%0d] got %0d exp 3", k, rf_wregnum); end
         checks++; if (stall_req !== (k >= 4)) begin errors++; $display("FAIL starve_stall[%0d] got %b exp %b", k, stall_req, k >= 4); end
      end
      p_valid = 1'b0;
      #1;
      checks++; if (s_ready !== 2'b01) begin errors++; $display("FAIL starve_accept got %b exp 01", s_ready); end
      cyc();
      checks++; if (stall_req !== 1'b0)      begin errors++; $display("FAIL starve_clear got %b exp 0", stall_req); end
      checks++; if (rf_wregnum !== 5'd12)    begin errors++; $display("FAIL starve_sec_rd got %0d exp 12", rf_wregnum); end
      checks++; if (rf_wd !== 32'h5555_AAAA) begin errors++; $display("FAIL starve_sec_wd got %h exp 5555aaaa", rf_wd); end
      idle_inputs();
      cyc();
   endtask

   // rr_ptr enters at 1; the x0 load grant flips it back to 0.
   task automatic test_rd_zero();
      s_valid = 2'b10; s_rd1 = 5'd0; s_data1 = 32'hFFFF_0000;
      #1;
      checks++; if (s_ready !== 2'b10) begin errors++; $display("FAIL rd0_ready got %b exp 10", s_ready); end
      cyc();
      checks++; if (rf_wr !== 1'b0)       begin errors++; $display("FAIL rd0_wr got %b exp 0", rf_wr); end
      checks++; if (rf_wregnum !== 5'd12) begin errors++; $display("FAIL rd0_hold_rd got %0d exp 12", rf_wregnum); end
      s_valid = 2'b11; s_rd0 = 5'd20; s_rd1 = 5'd21; s_data0 = 32'h2020; s_data1 = 32'h2121;
      #1;
      checks++; if (s_ready !== 2'b01) begin errors++; $display("FAIL rd0_ptr_toggle got %b exp 01", s_ready); end
      cyc();
      checks++; if (rf_wregnum !== 5'd20) begin errors++; $display("FAIL rd0_next_rd got %0d exp 20", rf_wregnum); end
      idle_inputs();
      cyc();
   endtask

   task automatic test_back_to_back();
      p_valid = 1'b1; p_rd = 5'd3; p_data = 32'hC3C3_C3C3;
      s_valid = 2'b01; s_rd0 = 5'd4; s_data0 = 32'hD4D4_D4D4;
      #1;
      checks++; if (s_ready !== 2'b00) begin errors++; $display("FAIL b2b_first_ready got %b exp 00", s_ready); end
      cyc();
      checks++; if (rf_wr !== 1'b1)          begin errors++; $display("FAIL b2b_first_wr got %b exp 1", rf_wr); end
      checks++; if (rf_wregnum !== 5'd3)     begin errors++; $display("FAIL b2b_first_rd got %0d exp 3", rf_wregnum); end
      checks++; if (rf_wd !== 32'hC3C3_C3C3) begin errors++; $display("FAIL b2b_first_wd got %h exp c3c3c3c3", rf_wd); end
      p_valid = 1'b0;
      #1;
      checks++; if (s_ready !== 2'b01) begin errors++; $display("FAIL b2b_second_ready got %b exp 01", s_ready); end
      cyc();
      s_valid = 2'b00;
      checks++; if (rf_wr !== 1'b1)          begin errors++; $display("FAIL b2b_second_wr got %b exp 1", rf_wr); end
      checks++; if (rf_wregnum !== 5'd4)     begin errors++; $display("FAIL b2b_second_rd got %0d exp 4", rf_wregnum); end
      checks++; if (rf_wd !== 32'hD4D4_D4D4) begin errors++; $display("FAIL b2b_second_wd got %h exp d4d4d4d4", rf_wd); end
      cyc();
      checks++; if (rf_wr !== 1'b0) begin errors++; $display("FAIL b2b_idle_wr got %b exp 0", rf_wr); end
   endtask

   initial begin
      test_reset();
      test_reset_mid_write();
      test_pipeline();
      test_round_robin();
      test_starvation();
      test_rd_zero();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port (RFWr / wregnum / WD) among three writeback sources:
  - main pipeline WB stage;
  - multi-cycle mul/div unit;
  - long-latency load-return path.
- The pipeline always has priority.
- The two secondary sources are served round-robin in free slots. A starvation counter forces a pipeline bubble when a secondary waits too long.
- Outputs are registered at posedge so the register file samples a stable write at the following negedge.

Parameters:
- XLEN, 32, data width
- RAW, 5, register address width
- STARVE_LIMIT, 4, consecutive blocked cycles before a secondary raises stall_req (1..15)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- p_valid  in  1  pipeline WB has a result this cycle; no backpressure
- p_rd  in  RAW  pipeline destination register
- p_data  in  XLEN  pipeline result
- s_valid  in  2  secondary requests; [0]=muldiv, [1]=load
- s_rd0, s_rd1  in  RAW  secondary destinations
- s_data0, s_data1  in  XLEN  secondary results
- s_ready  out  2  secondary accepted this cycle (combinational)
- stall_req  out  1  registered request to pipeline control to inject one WB bubble
- rf_wr  out  1  registered RF write enable (to RFWr)
- rf_wregnum  out  RAW  registered RF write address
- rf_wd  out  XLEN  registered RF write data

Behaviour:
- Reset (async, rst=1): rf_wr=0, rf_wregnum=0, rf_wd=0, stall_req=0, rr_ptr=0, both wait counters=0. Requests in flight at reset are dropped; they are not retried.
- Slot ownership each cycle:
  - pipe_hit = p_valid && p_rd!=0.
  - If pipe_hit: pipeline owns the port and s_ready=00.
  - Otherwise the port is free.
- A pipeline write with p_rd==0 is discarded and frees the slot.
- Free-slot grant:
  - One valid secondary: it is granted.
  - Both valid: grant index rr_ptr.
  - rr_ptr toggles to the other index after any secondary grant.
- At most one s_ready bit is high. s_ready depends only on current inputs and registered state (no loop through s_valid of the other requester beyond arbitration).
- Transfer occurs when s_valid[i] && s_ready[i]. The requester holds s_valid, s_rd and s_data stable until accepted.
- Write latency: a grant in cycle N produces rf_wr=1 with matching address and data after posedge N+1, so the RF writes at negedge of N+1.
- An idle cycle, or an accepted secondary with rd==0, produces rf_wr=0 next cycle. The transfer still completes and s_ready is still asserted.
- rf_wregnum and rf_wd hold their previous value when rf_wr=0.
- Starvation, per secondary i:
  - wait_cnt[i] increments on each cycle s_valid[i] && !s_ready[i], saturating at STARVE_LIMIT.
  - It clears on acceptance or when s_valid[i]=0.
  - stall_req(next) = any wait_cnt[i] reaches STARVE_LIMIT after the update, i.e. it rises in the cycle after the counter hits the limit.
  - stall_req clears the cycle after the starved requester is accepted.
- If p_valid stays high despite stall_req, the pipeline still wins and stall_req stays high. The pipeline is never blocked or dropped.
- Ordering: issue logic guarantees no two outstanding writes target the same rd. This block does not resolve WAW.

Decomposition:
- Package rf_pkg holds:
  - XLEN, RAW;
  - localparams SRC_MULDIV=0, SRC_LOAD=1;
  - typedef wb_req_t {valid, rd, data}.
- One sub-module, rr_arb2: two-way round-robin arbiter with an enable, returning a one-hot grant and an updated pointer.
- Starvation counters stay inline.

Test Plan:
- Reset mid-write: rf_wr=1 pending, assert rst asynchronously mid-cycle -> rf_wr, stall_req, rf_wregnum and rf_wd go 0 immediately, with no clock edge.
- Pipeline only: p_valid=1, p_rd=5, p_data=32'hDEAD_BEEF -> next cycle rf_wr=1, rf_wregnum=5, rf_wd=DEADBEEF. Same with p_rd=0 -> rf_wr=0.
- Both secondaries valid, pipeline idle, for 4 cycles, rd 7 and 9 -> grants alternate 0,1,0,1 starting from reset rr_ptr. Each grant produces rf_wr the following cycle with the correct rd and data.
- Pipeline writes every cycle while s_valid[0]=1, STARVE_LIMIT=4 -> s_ready=00, stall_req rises one cycle after the 4th blocked cycle. After p_valid drops for one cycle, s_ready[0]=1 and stall_req falls the next cycle.
- Secondary with s_rd1=0, pipeline idle -> s_ready[1]=1, rf_wr=0 next cycle, rr_ptr toggles.
- Pipeline p_rd=3 and s_valid[0] with s_rd0=4 in the same cycle -> RF writes reg 3 first, then reg 4 one cycle later. No data is lost and rf_wd matches each source.
